ascon_write_dma: RTL
====================

# ascon_write_dma

OBI write DMA engine that consumes the word-aligned little-endian stream produced by the ASCON read DMA or the ASCON core, and writes it to memory at an arbitrary byte address. It realigns the stream to the destination byte offset, generates per-word byte enables, and issues 32-bit OBI write transactions with bounded outstanding requests. It signals completion once every write response has returned.

## Interface
- MaxOutst, default 2: maximum OBI writes granted but not yet responded (1..7).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- testmode_i  in  1  test mode; unused by logic.
- mgr_req_o  out  mgr_obi_req_t  OBI manager request; we=1, aid=0.
- mgr_rsp_i  in  mgr_obi_rsp_t  OBI response (gnt, rvalid, r.err).
- awvalid  in  1  command valid.
- awready  out  1  command ready.
- awaddr  in  32  destination byte address, any alignment.
- awlen  in  32  byte count.
- wvalid  in  1  stream beat valid.
- wready  out  1  stream beat ready.
- wdata  in  32  stream data; stream byte 4k+i is in beat k, bits [8i+7:8i].
- wbe  in  4  stream byte enables; informational, ignored.
- wlast  in  1  final beat marker.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  error status; valid only while done_o=1.

## Operation
- Definitions: o=awaddr[1:0]; B=ceil(len/4) input beats; W=ceil((o+len)/4) OBI writes. W is either B or B+1.
- States:
  - IDLE: awready=1. A handshake latches addr, len and o. If len==0, go to DONE; otherwise go to RUN.
  - RUN: accepts exactly B beats. After the B-th beat is accepted, go to FLUSH if W==B+1, else go to DRAIN.
  - FLUSH: stages one final word built from the carry bytes, then goes to DRAIN.
  - DRAIN: waits until all W writes are granted and the outstanding count reaches 0, then goes to DONE.
  - DONE: done_o=1 for one cycle, then returns to IDLE.
- Realignment: OBI word j is written to address {addr[31:2],2'b00}+4j. Byte lane L of word j carries stream byte 4j+L-o.
  - A 3-byte carry register holds the upper o bytes of the previous beat.
  - The first word's lanes below o are not driven (be=0 there).
- Byte enables: lane L of word j is enabled iff 0 ≤ 4j+L-o < len. Disabled lanes drive data 0.
- Length authority: awlen alone sets the beat count. Bytes beyond len in the last beat are discarded. wlast is compared against the computed final beat; any mismatch sets the error flag.
- Output stage: one register holding addr, data, be and valid.
  - mgr_req_o.req = stage_valid && (oust < MaxOutst).
  - Once req is asserted it is held with a stable payload until gnt. The outstanding count cannot rise while req is waiting, so req never drops before gnt.
- wready = (state==RUN) && beats_left>0 && (!stage_valid || (req && gnt)).
- Outstanding counter oust:
  - +1 on req&&gnt.
  - −1 on rvalid.
  - Unchanged when both occur in the same cycle.
  - Counts 0..MaxOutst, never wraps.
- Error flag: cleared on command accept. Set by rvalid with r.err=1, or by a wlast mismatch. err_o = flag while done_o=1, else 0.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no special handling.

## Timing
- Reset values: state IDLE, awready=1, wready=0, req=0, done_o=0, err_o=0, oust=0, stage_valid=0.
- Reset asserted mid-operation aborts immediately. Late OBI responses after reset deassertion are ignored while in IDLE (oust stays 0).
- Command accepted in cycle 0 → wready may rise in cycle 1.
- Beat accepted in cycle t → req asserted in cycle t+1 if oust<MaxOutst.
- With gnt in the same cycle and rvalid one cycle later, throughput is one word per cycle at MaxOutst=2.
- len==0: done_o pulses in cycle 1. No beats are accepted and no req is issued.
- done_o asserts the cycle after the last rvalid drives oust to 0 in DRAIN.
- awready=0 from command accept until the cycle after done_o.

## Test plan
- Aligned write: awaddr=0x1000, len=8, beats 0x03020100 and 0x07060504, gnt always high, rvalid one cycle after gnt → writes (0x1000, be 1111, 0x03020100) then (0x1004, be 1111, 0x07060504); done_o pulses once; err_o=0.
- Offset with flush: awaddr=0x1001, len=4, beat 0x03020100 → writes (0x1000, be 1110, 0x02010000) then (0x1004, be 0001, 0x00000003). FLUSH is visited and no extra beat is accepted.
- Single byte at top lane: awaddr=0x2003, len=1, beat 0x000000AA → one write (0x2000, be 1000, 0xAA000000), then done_o.
- Backpressure: gnt held low 5 cycles, then rvalid delayed 3 cycles after each gnt → payload stable while req&&!gnt; wready stays low while the stage is full; oust never exceeds 2; req is deasserted only when oust==2.
- Zero length and errors: len=0 → no req, done_o in cycle 1. len=8 with r.err=1 on the second response → err_o=1 during done_o. len=8 with wlast on beat 0 → 2 beats still accepted, err_o=1.
- Reset mid-operation: rst_ni low in RUN with oust=1 → req=0 and awready=1 immediately. A stray rvalid after reset release leaves oust=0, and a new command completes normally.

Source files
------------

// File: rtl/ascon_write_dma.sv
// ascon_write_dma: OBI write DMA for the ASCON stream.
// Takes word-aligned little-endian beats, shifts them onto the destination
// byte offset, and issues 32-bit OBI writes with masked byte enables.
// The number of writes in flight is bounded by MaxOutst.

package ascon_write_dma_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
    } obi_a_t;

    typedef struct packed {
        logic   req;
        obi_a_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } obi_r_t;

    typedef struct packed {
        logic   gnt;
        logic   rvalid;
        obi_r_t r;
    } mgr_obi_rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

module ascon_write_dma
    import ascon_write_dma_pkg::*;
#(
    parameter int unsigned MaxOutst = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         testmode_i,
    output mgr_obi_req_t mgr_req_o,
    input  mgr_obi_rsp_t mgr_rsp_i,
    input  logic         awvalid,
    output logic         awready,
    input  logic [31:0]  awaddr,
    input  logic [31:0]  awlen,
    input  logic         wvalid,
    output logic         wready,
    input  logic [31:0]  wdata,
    input  logic [3:0]   wbe,
    input  logic         wlast,
    output logic         done_o,
    output logic         err_o
);

    localparam logic [2:0] MaxOutstW = 3'(MaxOutst);

    state_e      state_q, state_d;
    logic [31:0] waddr_q, waddr_d;          // address of the next word to stage
    logic [31:0] widx_q, widx_d;            // index j of the next word to stage
    logic [31:0] len_q, len_d;
    logic [1:0]  off_q, off_d;
    logic [30:0] beats_left_q, beats_left_d;
    logic        flush_q, flush_d;          // one more word than beats
    logic [23:0] carry_q, carry_d;          // upper bytes of the previous beat
    logic        stage_valid_q, stage_valid_d;
    logic [31:0] stage_addr_q, stage_addr_d;
    logic [31:0] stage_data_q, stage_data_d;
    logic [3:0]  stage_be_q, stage_be_d;
    logic [2:0]  oust_q, oust_d;
    logic        err_q, err_d;

    logic        cmd_fire, beat_fire, last_beat;
    logic        req, granted, stage_free;
    logic [32:0] sum_b;
    logic [33:0] sum_w;
    logic [30:0] beats_b;
    logic [31:0] words_w;
    logic        flush_calc;
    logic [55:0] cat;
    logic [31:0] word_raw, word_data;
    logic [3:0]  word_be;
    logic [34:0] lane_pos;

    // Test mode, the informational stream enables and read data play no part.
    logic unused_sigs;
    assign unused_sigs = ^{testmode_i, wbe, mgr_rsp_i.r.rdata};

    assign cmd_fire   = awvalid && awready;
    assign beat_fire  = wvalid && wready;
    assign last_beat  = (beats_left_q == 31'd1);
    assign req        = stage_valid_q && (oust_q < MaxOutstW);
    assign granted    = req && mgr_rsp_i.gnt;
    assign stage_free = !stage_valid_q || granted;

    // Beat count B and whether the offset pushes the tail into an extra word.
    assign sum_b      = {1'b0, awlen} + 33'd3;
    assign beats_b    = sum_b[32:2];
    assign sum_w      = {2'b00, awlen} + {32'b0, awaddr[1:0]} + 34'd3;
    assign words_w    = sum_w[33:2];
    assign flush_calc = (words_w != {1'b0, beats_b});

    // Build word j from the current beat (or zeros in FLUSH) and the carry bytes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cat       = (state_q == ST_FLUSH) ? {32'h0, carry_q} : {wdata, carry_q};
        word_raw  = '0;
        word_be   = '0;
        word_data = '0;
        lane_pos  = '0;
        unique case (off_q)
            2'd0:    word_raw = cat[55:24];
            2'd1:    word_raw = cat[47:16];
            2'd2:    word_raw = cat[39:8];
            default: word_raw = cat[31:0];
        endcase
        for (int l = 0; l < 4; l++) begin
            lane_pos   = {1'b0, widx_q, 2'b00} + 35'(l);
            word_be[l] = (lane_pos >= 35'(off_q)) &&
                         ((lane_pos - 35'(off_q)) < 35'(len_q));
            word_data[8*l +: 8] = word_be[l] ? word_raw[8*l +: 8] : 8'h00;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cmd_fire) state_d = (awlen == 32'd0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (beat_fire && last_beat) state_d = flush_q ? ST_FLUSH : ST_DRAIN;
            ST_FLUSH: if (stage_free) state_d = ST_DRAIN;
            ST_DRAIN: if (!stage_valid_q && (oust_d == 3'd0)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes, completion and the OBI request.
    always_comb begin
        awready             = (state_q == ST_IDLE);
        wready              = (state_q == ST_RUN) && (beats_left_q != 31'd0) && stage_free;
        done_o              = (state_q == ST_DONE);
        err_o               = (state_q == ST_DONE) && err_q;
        mgr_req_o           = '0;
        mgr_req_o.req       = req;
        mgr_req_o.a.addr    = stage_addr_q;
        mgr_req_o.a.we      = 1'b1;
        mgr_req_o.a.be      = stage_be_q;
        mgr_req_o.a.wdata   = stage_data_q;
        mgr_req_o.a.aid     = 1'b0;
    end

    // Datapath next state: command latch, staging, outstanding count, error flag.
    always_comb begin
        waddr_d       = waddr_q;
        widx_d        = widx_q;
        len_d         = len_q;
        off_d         = off_q;
        beats_left_d  = beats_left_q;
        flush_d       = flush_q;
        carry_d       = carry_q;
        stage_valid_d = stage_valid_q;
        stage_addr_d  = stage_addr_q;
        stage_data_d  = stage_data_q;
        stage_be_d    = stage_be_q;
        oust_d        = oust_q;
        err_d         = err_q;

        if (cmd_fire) begin
            waddr_d      = {awaddr[31:2], 2'b00};
            widx_d       = '0;
            len_d        = awlen;
            off_d        = awaddr[1:0];
            beats_left_d = beats_b;
            flush_d      = flush_calc;
            carry_d      = '0;
        end

        if (granted) stage_valid_d = 1'b0;

        if (beat_fire || ((state_q == ST_FLUSH) && stage_free)) begin
            stage_valid_d = 1'b1;
            stage_addr_d  = waddr_q;
            stage_data_d  = word_data;
            stage_be_d    = word_be;
            waddr_d       = waddr_q + 32'd4;
            widx_d        = widx_q + 32'd1;
        end

        if (beat_fire) begin
            beats_left_d = beats_left_q - 31'd1;
            carry_d      = wdata[31:8];
        end

        // Responses arriving while idle belong to an aborted transfer.
        if (state_q == ST_IDLE) begin
            oust_d = '0;
        end else if (granted && !mgr_rsp_i.rvalid) begin
            oust_d = oust_q + 3'd1;
        end else if (!granted && mgr_rsp_i.rvalid && (oust_q != 3'd0)) begin
            oust_d = oust_q - 3'd1;
        end

        if (cmd_fire) begin
            err_d = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if ((mgr_rsp_i.rvalid && mgr_rsp_i.r.err) || (beat_fire && (wlast != last_beat)))
                err_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            waddr_q       <= '0;
            widx_q        <= '0;
            len_q         <= '0;
            off_q         <= '0;
            beats_left_q  <= '0;
            flush_q       <= 1'b0;
            carry_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
            stage_be_q    <= '0;
            oust_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            waddr_q       <= waddr_d;
            widx_q        <= widx_d;
            len_q         <= len_d;
            off_q         <= off_d;
            beats_left_q  <= beats_left_d;
            flush_q       <= flush_d;
            carry_q       <= carry_d;
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_data_q  <= stage_data_d;
            stage_be_q    <= stage_be_d;
            oust_q        <= oust_d;
            err_q         <= err_d;
        end
    end

endmodule
